// File: rtl/sample_buffer_pkg.sv
// Shared constants, FSM encoding and Hann coefficient generator for the sample_buffer slice.
package sample_buffer_pkg;

   localparam int unsigned SAMPLE_WIDTH = 16;
   localparam int unsigned SAMPLE_NUM   = 1024;
   localparam int unsigned ADDR_WIDTH   = $clog2(SAMPLE_NUM);
   localparam int unsigned DATA_WIDTH   = 32;
   localparam int unsigned COEFF_WIDTH  = 16;
   localparam int unsigned COEFF_FRAC   = 15;

   typedef enum logic {
      EMPTY = 1'b0,
      RUN   = 1'b1
   } state_e;

   // Hann w[n] = sin^2(pi*n/N) in unsigned Q1.15, using Bhaskara's rational sine
   // approximation so the table is built from integer constant arithmetic only.
   function automatic logic [COEFF_WIDTH-1:0] hann_coeff(input int unsigned n);
      longint unsigned t, nn, p, num, den, w;
      t   = longint'(n);
      nn  = longint'(SAMPLE_NUM);
      p   = t * (nn - t);
      num = 16 * p;
      den = 5 * nn * nn - 4 * p;
      w   = ((num * num) << COEFF_FRAC) / (den * den);
      return COEFF_WIDTH'(w);
   endfunction

endpackage

// File: rtl/sample_buffer_if.sv
// Sample stream in, FFT buffer port out, and status of the ping-pong frame store.
interface sample_buffer_if;
   import sample_buffer_pkg::*;

   logic signed [SAMPLE_WIDTH-1:0] sample_i;
   logic                           sample_valid_i;
   logic                           fft_busy_i;
   logic [ADDR_WIDTH-1:0]          address_i;
   logic [DATA_WIDTH-1:0]          data_o;
   logic                           start_o;
   logic                           read_bank_o;
   logic                           overflow_o;
   logic                           overflow_clr_i;

   modport master (
      output sample_i, sample_valid_i, fft_busy_i, address_i, overflow_clr_i,
      input  data_o, start_o, read_bank_o, overflow_o
   );

   modport slave (
      input  sample_i, sample_valid_i, fft_busy_i, address_i, overflow_clr_i,
      output data_o, start_o, read_bank_o, overflow_o
   );

endinterface

// File: rtl/sample_buffer_hann_window_rom.sv
// Hann coefficient ROM (SAMPLE_NUM x COEFF_WIDTH, registered read); only built with SAMPLE_BUFFER_WINDOW_EN.
`ifdef SAMPLE_BUFFER_WINDOW_EN
module hann_window_rom
   import sample_buffer_pkg::*;
(
   input  logic                   clk,
   input  logic [ADDR_WIDTH-1:0]  addr_i,
   output logic [COEFF_WIDTH-1:0] coeff_o
);

   logic [COEFF_WIDTH-1:0] rom [SAMPLE_NUM];
   logic [COEFF_WIDTH-1:0] coeff_q;

   for (genvar i = 0; i < SAMPLE_NUM; i++) begin : g_rom
      assign rom[i] = hann_coeff(i);
   end

   always_ff @(posedge clk) begin
      coeff_q <= rom[addr_i];
   end

   assign coeff_o = coeff_q;

endmodule
`endif

// File: rtl/sample_buffer.sv
// Ping-pong frame store feeding the FFT: fills one bank while the FFT reads the other.
// Define SAMPLE_BUFFER_WINDOW_EN to apply a Hann window (one extra write-path stage).
module sample_buffer
   import sample_buffer_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   sample_buffer_if.slave bus
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic                    read_bank_q, read_bank_d;
   logic                    start_q, start_d;
   logic                    overflow_q, overflow_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;

   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_idx;
   logic [SAMPLE_WIDTH-1:0] wr_data;
   logic                    last_wr, swap, drop;

   logic [SAMPLE_WIDTH-1:0] mem_q [2*SAMPLE_NUM];
   logic [SAMPLE_WIDTH-1:0] rd_word;

   assign wr_ptr_d = bus.sample_valid_i ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;

`ifdef SAMPLE_BUFFER_WINDOW_EN
   localparam int unsigned PROD_WIDTH = SAMPLE_WIDTH + COEFF_WIDTH + 1;

   logic [COEFF_WIDTH-1:0]        coeff;
   logic                          win_valid_q;
   logic [SAMPLE_WIDTH-1:0]       win_sample_q;
   logic [ADDR_WIDTH-1:0]         win_ptr_q;
   logic signed [PROD_WIDTH-1:0]  s_ext, c_ext, product, scaled;

   hann_window_rom u_rom (
      .clk    (clk),
      .addr_i (wr_ptr_q),
      .coeff_o(coeff)
   );

   // Sample and pointer are delayed to line up with the registered coefficient.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_valid_q  <= 1'b0;
         win_sample_q <= '0;
         win_ptr_q    <= '0;
      end else begin
         win_valid_q  <= bus.sample_valid_i;
         win_sample_q <= bus.sample_i;
         win_ptr_q    <= wr_ptr_q;
      end
   end

   assign s_ext   = PROD_WIDTH'($signed(win_sample_q));
   assign c_ext   = PROD_WIDTH'({1'b0, coeff});
   assign product = s_ext * c_ext;
   assign scaled  = product >>> COEFF_FRAC;

   assign wr_en   = win_valid_q;
   assign wr_idx  = win_ptr_q;
   assign wr_data = scaled[SAMPLE_WIDTH-1:0];
`else
   assign wr_en   = bus.sample_valid_i;
   assign wr_idx  = wr_ptr_q;
   assign wr_data = bus.sample_i;
`endif

   // Busy only matters at the committing write of a frame.
   assign last_wr = wr_en && (&wr_idx);
   assign swap    = last_wr && !bus.fft_busy_i;
   assign drop    = last_wr &&  bus.fft_busy_i;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[{~read_bank_q, wr_idx}] <= wr_data;
      end
   end

   assign rd_word = mem_q[{read_bank_q, bus.address_i}];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (swap) state_d = RUN;
         RUN:   state_d = RUN;
      endcase
   end

   always_comb begin
      start_d     = swap;
      read_bank_d = read_bank_q ^ swap;
      overflow_d  = drop ? 1'b1 : (bus.overflow_clr_i ? 1'b0 : overflow_q);
      data_d      = '0;
      if (state_q == RUN) begin
         data_d = DATA_WIDTH'($signed(rd_word));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         read_bank_q <= 1'b0;
         start_q     <= 1'b0;
         overflow_q  <= 1'b0;
         data_q      <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         read_bank_q <= read_bank_d;
         start_q     <= start_d;
         overflow_q  <= overflow_d;
         data_q      <= data_d;
      end
   end

   assign bus.data_o      = data_q;
   assign bus.start_o     = start_q;
   assign bus.read_bank_o = read_bank_q;
   assign bus.overflow_o  = overflow_q;

endmodule
